slice_packer: RTL and testbench

//  Inverse of the parameterized slice splitter: gathers OFFSET-bit slices arriving one
//  per valid/ready handshake and reassembles them into a WIDTH-bit word.

---
 rtl/slice_pkg.sv | 19 +
 rtl/slice_beat_ctr.sv | 26 ++
 rtl/slice_packer.sv | 106 ++++++++++
 tb/tb_slice_packer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/slice_pkg.sv
// Shared sizing helpers and state encoding for the slice packer and its splitter counterpart.
package slice_pkg;

  typedef enum logic {COLLECT, FULL} state_t;

  function automatic int beats(input int w, input int o);
    return (w + o - 1) / o;
  endfunction

  function automatic int rem_bits(input int w, input int o);
    return w - (beats(w, o) - 1) * o;
  endfunction

  // Beat counter width, never narrower than one bit so BEATS==1 still has a counter.
  function automatic int ctr_width(input int b);
    return (b <= 1) ? 1 : $clog2(b);
  endfunction

endpackage

// File: rtl/slice_beat_ctr.sv
// Beat index within the word being assembled; wraps at BEATS and can be forced back to zero.
module slice_beat_ctr #(
  parameter int BEATS = 2,
  parameter int CW    = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] beat,
  output logic          is_last
);

  assign is_last = (beat == CW'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat <= '0;
    end else if (clear) begin
      beat <= '0;
    end else if (inc) begin
      beat <= is_last ? '0 : beat + CW'(1);
    end
  end

endmodule

// File: rtl/slice_packer.sv
// Reassembles OFFSET-bit slices into a WIDTH-bit word held in a single output register.
module slice_packer
  import slice_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int OFFSET    = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OFFSET-1:0] in_slice,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_short
);

  localparam int BEATS = beats(WIDTH, OFFSET);
  localparam int REM   = rem_bits(WIDTH, OFFSET);
  localparam int CW    = ctr_width(BEATS);

  state_t           state;
  logic [WIDTH-1:0] data_q;
  logic             short_q;
  logic [CW-1:0]    beat;
  logic             is_last;
  logic             accept;
  logic             closing;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] slice_bits;
  logic [WIDTH-1:0] next_word;

  assign in_ready  = (state == COLLECT) || out_ready;
  assign accept    = in_valid && in_ready;
  assign closing   = accept && (is_last || in_last);
  assign out_valid = (state == FULL);
  assign out_data  = data_q;
  assign out_short = short_q;

  slice_beat_ctr #(.BEATS(BEATS), .CW(CW)) u_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (closing),
    .inc    (accept),
    .beat   (beat),
    .is_last(is_last)
  );

  // Each output bit knows at elaboration which beat owns it and which slice bit feeds it;
  // in MSB-first order beat 0 owns the REM-wide top slice.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int K = LSB_FIRST ? (i / OFFSET)
                     : ((i >= WIDTH - REM) ? 0 : (BEATS - 1 - i / OFFSET));
    localparam int J = LSB_FIRST ? (i % OFFSET)
                     : ((i >= WIDTH - REM) ? (i - (WIDTH - REM)) : (i % OFFSET));
    assign hit[i]        = (beat == CW'(K));
    assign slice_bits[i] = in_slice[J];
  end

  // Leaving FULL starts from a zero accumulator so a short word never inherits stale bits.
  assign base      = (state == FULL) ? '0 : data_q;
  assign next_word = (base & ~hit) | (slice_bits & hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= COLLECT;
      data_q  <= '0;
      short_q <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            data_q <= next_word;
            if (closing) begin
              state   <= FULL;
              short_q <= in_last && !is_last;
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            if (accept) begin
              data_q <= next_word;
              if (closing) begin
                short_q <= in_last && !is_last;
              end else begin
                state   <= COLLECT;
                short_q <= 1'b0;
              end
            end else begin
              state   <= COLLECT;
              data_q  <= '0;
              short_q <= 1'b0;
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_slice_packer.sv
// Scoreboard bench for slice_packer: three parameterisations share one clock and stimulus path.
module tb_slice_packer;

  typedef struct {
    logic [9:0] data;
    logic       short_f;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sel = 2'd0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b1;
  logic [3:0] in_slice = 4'h0;

  logic [2:0] iv, ir, ov, osh;
  logic [7:0] od_a, od_c;
  logic [9:0] od_b;
  logic       cur_ready, cur_valid, cur_short;
  logic [9:0] cur_data;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   last_pop = 0;
  int   prev_pop = 0;

  always #5 clk = ~clk;

  assign iv = {in_valid && (sel == 2'd2), in_valid && (sel == 2'd1), in_valid && (sel == 2'd0)};

  slice_packer #(.WIDTH(8), .OFFSET(4), .LSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_slice(in_slice),
    .in_last(in_last), .out_valid(ov[0]), .out_ready(out_ready), .out_data(od_a), .out_short(osh[0])
  );

  slice_packer #(.WIDTH(10), .OFFSET(4), .LSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_slice(in_slice),
    .in_last(in_last), .out_valid(ov[1]), .out_ready(out_ready), .out_data(od_b), .out_short(osh[1])
  );

  slice_packer #(.WIDTH(8), .OFFSET(4), .LSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_slice(in_slice),
    .in_last(in_last), .out_valid(ov[2]), .out_ready(out_ready), .out_data(od_c), .out_short(osh[2])
  );

  assign cur_ready = ir[sel];
  assign cur_valid = ov[sel];
  assign cur_short = osh[sel];
  assign cur_data  = (sel == 2'd1) ? od_b : {2'b00, (sel == 2'd0) ? od_a : od_c};

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic pushExpected(input logic [9:0] d, input logic s);
    exp_t e;
    e.data    = d;
    e.short_f = s;
    sb.push_back(e);
  endtask

  // Drives one slice and holds it until the selected packer accepts it.
  task automatic applyStimulus(input logic [3:0] s, input logic l);
    int n = 0;
    in_slice = s;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!cur_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ready) checkOutput("in_ready_timeout", 32'(cur_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic waitDrain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    cycle++;
    if (rst_n && cur_valid && out_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("word_data", 32'(cur_data), 32'(e.data));
        checkOutput("word_short", 32'(cur_short), 32'(e.short_f));
      end
      prev_pop = last_pop;
      last_pop = cycle;
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(cur_valid), 32'd0);
    checkOutput("rst_ready", 32'(cur_ready), 32'd1);
    checkOutput("rst_data", 32'(cur_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic LSB-first word and one-cycle output latency
    pushExpected(10'h05A, 1'b0);
    applyStimulus(4'hA, 1'b0);
    checkOutput("t1_not_yet_valid", 32'(cur_valid), 32'd0);
    applyStimulus(4'h5, 1'b0);
    checkOutput("t1_valid_latency", 32'(cur_valid), 32'd1);
    waitDrain("t1_drain");

    // Short word straight after a full one must not carry stale bits
    pushExpected(10'h007, 1'b1);
    applyStimulus(4'h7, 1'b1);
    waitDrain("t3_drain");
    pushExpected(10'h016, 1'b0);
    applyStimulus(4'h6, 1'b0);
    applyStimulus(4'h1, 1'b1);
    waitDrain("t3_redundant_last");

    // Backpressure hold, then simultaneous consume and accept
    out_ready = 1'b0;
    pushExpected(10'h0C3, 1'b0);
    applyStimulus(4'h3, 1'b0);
    applyStimulus(4'hC, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("t4_hold_valid", 32'(cur_valid), 32'd1);
      checkOutput("t4_hold_ready", 32'(cur_ready), 32'd0);
      checkOutput("t4_hold_data", 32'(cur_data), 32'h0C3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    pushExpected(10'h019, 1'b0);
    in_slice = 4'h9;
    in_valid = 1'b1;
    @(negedge clk);
    checkOutput("t4_cons_ready", 32'(cur_ready), 32'd1);
    checkOutput("t4_cons_valid", 32'(cur_valid), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    applyStimulus(4'h1, 1'b0);
    waitDrain("t4_drain");

    // Non-multiple width: final beat keeps only its low REM bits
    sel = 2'd1;
    pushExpected(10'h321, 1'b0);
    applyStimulus(4'h1, 1'b0);
    applyStimulus(4'h2, 1'b0);
    applyStimulus(4'hF, 1'b0);
    waitDrain("t2_drain");
    pushExpected(10'h004, 1'b1);
    applyStimulus(4'h4, 1'b1);
    waitDrain("t2_short_drain");

    // MSB-first order, short word, and back-to-back throughput
    sel = 2'd2;
    pushExpected(10'h0A5, 1'b0);
    applyStimulus(4'hA, 1'b0);
    applyStimulus(4'h5, 1'b0);
    waitDrain("t5_drain");
    pushExpected(10'h070, 1'b1);
    applyStimulus(4'h7, 1'b1);
    waitDrain("t5_short_drain");
    pushExpected(10'h012, 1'b0);
    pushExpected(10'h034, 1'b0);
    pushExpected(10'h056, 1'b0);
    for (int w = 0; w < 3; w++) begin
      applyStimulus(4'(2 * w + 1), 1'b0);
      applyStimulus(4'(2 * w + 2), 1'b0);
    end
    @(negedge clk);
    #1;
    checkOutput("t5_word_spacing", 32'(last_pop - prev_pop), 32'd2);
    waitDrain("t5_stream_drain");

    // Reset in the middle of a word discards it
    sel = 2'd0;
    applyStimulus(4'h9, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", 32'(cur_valid), 32'd0);
    checkOutput("t6_rst_data", 32'(cur_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    pushExpected(10'h043, 1'b0);
    applyStimulus(4'h3, 1'b0);
    applyStimulus(4'h4, 1'b0);
    waitDrain("t6_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
